mp1_mem_responder: RTL

Synthesizable responder end of the mp1 memory interface: accepts the CPU's read/write requests (mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata) and answers with mem_resp/mem_rdata after a fixed, parameterized latency. It replaces the behavioural memory model when mp1 runs on FPGA or in cycle-accurate system simulation, and lets benches stress the CPU's wait-for-resp logic.

---
 rtl/mp1_mem_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mp1_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : mp1_mem_responder
// Purpose  : Responder end of the mp1 memory interface. Accepts held
//            read/write requests and returns a single-cycle resp pulse
//            (with rdata for reads) after DELAY busy cycles. Backed by a
//            2**DEPTH_LOG2 x 16-bit array with per-byte write enables.
// Options  : `define PROTOCOL_CHECK_EN to build the sticky proto_err
//            checker. Without it, proto_err is tied low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mp1_mem_responder #(
   parameter int DELAY      = 3,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [1:0]  wmask,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   output logic        resp,
   output logic [15:0] rdata,
   output logic        proto_err
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_BUSY     = 2'd1;
   localparam logic [1:0] c_RESP     = 2'd2;
   localparam logic [7:0] c_CNT_INIT = 8'(DELAY - 1);
   localparam int         c_WORDS    = 1 << DEPTH_LOG2;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [7:0]            r_cnt;
   logic [7:0]            w_next_cnt;
   logic [15:0]           r_mem [0:c_WORDS-1];
   logic [15:0]           r_rdata;
   logic [DEPTH_LOG2-1:0] w_word;
   logic                  w_req;
   logic                  w_start;
   logic                  w_abort;
   logic                  w_access;
   logic                  w_do_write;
   logic                  w_do_read;
   logic                  w_unused_addr;

   // Byte address -> word index; bit 0 and bits above the array alias away.
   assign w_word        = address[DEPTH_LOG2:1];
   assign w_unused_addr = ^{address[15:DEPTH_LOG2+1], address[0]};
   assign w_req         = read | write;

   // Write wins when both request lines are high.
   assign w_do_write = w_access & write;
   assign w_do_read  = w_access & ~write;

   // State and latency counter registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next-state logic: count down in BUSY, access on the zero-count edge.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_start      = 1'b0;
      w_abort      = 1'b0;
      w_access     = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_req) begin
               w_next_state = c_BUSY;
               w_next_cnt   = c_CNT_INIT;
               w_start      = 1'b1;
            end
         end
         c_BUSY: begin
            if (!w_req) begin
               w_next_state = c_IDLE;
               w_abort      = 1'b1;
            end else if (r_cnt != 8'd0) begin
               w_next_cnt   = r_cnt - 8'd1;
            end else begin
               w_next_state = c_RESP;
               w_access     = 1'b1;
            end
         end
         c_RESP: begin
            // Request lines are ignored here; always return to IDLE.
            w_next_state = c_IDLE;
         end
         default: begin
            w_next_state = c_IDLE;
         end
      endcase
   end

   // Outputs: resp decodes the registered RESP state, so it is glitch-free.
   always_comb begin
      resp  = (r_state == c_RESP);
      rdata = r_rdata;
   end

   // Storage array: not reset; a write is suppressed if rst is high on its edge.
   always_ff @(posedge clk) begin
      if (!rst && w_do_write) begin
         if (wmask[1]) r_mem[w_word][15:8] <= wdata[15:8];
         if (wmask[0]) r_mem[w_word][7:0]  <= wdata[7:0];
      end
   end

   // Read data register: loads only on a read access, otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= 16'h0000;
      end else if (w_do_read) begin
         r_rdata <= r_mem[w_word];
      end
   end

`ifdef PROTOCOL_CHECK_EN
   logic        r_cap_read;
   logic        r_cap_write;
   logic [1:0]  r_cap_wmask;
   logic [15:0] r_cap_address;
   logic [15:0] r_cap_wdata;
   logic        r_proto_err;
   logic        w_changed;

   assign w_changed = ({read, write, wmask, address, wdata} !=
                       {r_cap_read, r_cap_write, r_cap_wmask, r_cap_address, r_cap_wdata});

   // Capture the request on entry to BUSY and flag any later deviation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cap_read    <= 1'b0;
         r_cap_write   <= 1'b0;
         r_cap_wmask   <= 2'b00;
         r_cap_address <= 16'h0000;
         r_cap_wdata   <= 16'h0000;
         r_proto_err   <= 1'b0;
      end else begin
         if (w_start) begin
            r_cap_read    <= read;
            r_cap_write   <= write;
            r_cap_wmask   <= wmask;
            r_cap_address <= address;
            r_cap_wdata   <= wdata;
            if (read && write) r_proto_err <= 1'b1;
         end
         if (r_state == c_BUSY && (w_abort || w_changed)) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign proto_err = r_proto_err;
`else
   assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire
